// File: rtl/demux1to16_reg_n_pkg.sv
// Shared types and default sizes for the registered 1-to-m demux and its sibling mux16to1_n.
package demux1to16_reg_n_pkg;

    localparam int DEF_N       = 4;
    localparam int DEF_ADDRESS = 4;
    localparam int DEF_M       = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/decoder_n.sv
// Address to one-hot decoder with enable; addresses at or beyond m decode to all zeros.
module decoder_n #(
    parameter int address = 4,
    parameter int m       = 16
) (
    input  logic [address-1:0] addr,
    input  logic               en,
    output logic [m-1:0]       onehot
);

    always_comb begin
        onehot = '0;
        for (int k = 0; k < m; k++) begin
            if (en && (addr == address'(k))) onehot[k] = 1'b1;
        end
    end

endmodule

// File: rtl/demux1to16_reg_n.sv
// Registered 1-to-m lane demux: addressed writes in IDLE, sequential lane fill with stall support.
module demux1to16_reg_n
    import demux1to16_reg_n_pkg::*;
#(
    parameter int n       = DEF_N,
    parameter int address = DEF_ADDRESS,
    parameter int m       = DEF_M
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [n-1:0]       data_i,
    input  logic [address-1:0] sel_i,
    input  logic               wr_i,
    input  logic               fill_i,
    input  logic               clear_i,
    output logic [n-1:0]       data_o [0:m-1],
    output logic [m-1:0]       valid_o,
    output logic               busy_o,
    output logic               done_o
);

    localparam logic [address-1:0] LAST = address'(m - 1);

    state_t             state, state_nxt;
    logic [address-1:0] cnt, cnt_nxt;
    logic [address-1:0] lane_addr;
    logic               lane_en;
    logic [m-1:0]       lane_we;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Priority clear > fill > wr; the decoder address comes from sel_i in IDLE, the counter in FILL.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        lane_addr = sel_i;
        lane_en   = 1'b0;
        if (clear_i) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (fill_i) begin
                        state_nxt = FILL;
                        cnt_nxt   = '0;
                    end else begin
                        lane_en = wr_i;
                    end
                end
                FILL: begin
                    lane_addr = cnt;
                    if (wr_i) begin
                        lane_en = 1'b1;
                        if (cnt == LAST) begin
                            state_nxt = DONE;
                            cnt_nxt   = '0;
                        end else begin
                            cnt_nxt = cnt + 1'b1;
                        end
                    end
                end
                DONE:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    decoder_n #(
        .address(address),
        .m      (m)
    ) u_dec (
        .addr  (lane_addr),
        .en    (lane_en),
        .onehot(lane_we)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int k = 0; k < m; k++) data_o[k] <= '0;
            valid_o <= '0;
        end else if (clear_i) begin
            for (int k = 0; k < m; k++) data_o[k] <= '0;
            valid_o <= '0;
        end else begin
            for (int k = 0; k < m; k++) begin
                if (lane_we[k]) begin
                    data_o[k]  <= data_i;
                    valid_o[k] <= 1'b1;
                end
            end
        end
    end

    // Status is decoded from the state register only.
    assign busy_o = (state != IDLE);
    assign done_o = (state == DONE);

endmodule

// File: tb/tb_demux1to16_reg_n.sv
// Scoreboard bench: a 16-lane and a 12-lane instance share stimulus; a behavioural model predicts every cycle.
module tb_demux1to16_reg_n;

    typedef struct packed {
        logic [1:0]       st;    // 0 idle, 1 fill, 2 done
        logic [3:0]       cnt;
        logic [15:0][3:0] lane;
        logic [15:0]      valid;
    } mdl_t;

    typedef struct packed {
        mdl_t a;
        mdl_t b;
    } exp_t;

    logic       clk, rst, wr, fill, clr;
    logic [3:0] data, sel;
    logic [3:0] d16 [0:15];
    logic [3:0] d12 [0:11];
    logic [15:0] v16;
    logic [11:0] v12;
    logic busy16, done16, busy12, done12;

    int n_tests = 0, n_fail = 0;
    int cyc = 0, done_cnt = 0, done_edge = -1, fill_edge = 0;
    mdl_t m16, m12, saved;
    exp_t sb_q[$];

    demux1to16_reg_n #(.n(4), .address(4), .m(16)) u_dut16 (
        .clk_i(clk), .rst_i(rst), .data_i(data), .sel_i(sel), .wr_i(wr),
        .fill_i(fill), .clear_i(clr), .data_o(d16), .valid_o(v16),
        .busy_o(busy16), .done_o(done16)
    );

    demux1to16_reg_n #(.n(4), .address(4), .m(12)) u_dut12 (
        .clk_i(clk), .rst_i(rst), .data_i(data), .sel_i(sel), .wr_i(wr),
        .fill_i(fill), .clear_i(clr), .data_o(d12), .valid_o(v12),
        .busy_o(busy12), .done_o(done12)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    function automatic mdl_t step(input mdl_t s, input int mm);
        mdl_t o = s;
        if (clr) begin
            o = '0;
        end else begin
            case (s.st)
                2'd0: begin
                    if (fill) begin
                        o.st = 2'd1; o.cnt = 4'd0;
                    end else if (wr && int'(sel) < mm) begin
                        o.lane[sel] = data; o.valid[sel] = 1'b1;
                    end
                end
                2'd1: begin
                    if (wr) begin
                        o.lane[s.cnt] = data; o.valid[s.cnt] = 1'b1;
                        if (int'(s.cnt) == mm - 1) begin
                            o.st = 2'd2; o.cnt = 4'd0;
                        end else begin
                            o.cnt = s.cnt + 4'd1;
                        end
                    end
                end
                default: o.st = 2'd0;
            endcase
        end
        return o;
    endfunction

    // Drive is already set; push prediction, take the edge, pop and compare one cycle of output.
    task automatic cycle();
        exp_t e;
        m16 = step(m16, 16);
        m12 = step(m12, 12);
        sb_q.push_back('{a: m16, b: m12});
        @(posedge clk);
        #1;
        cyc++;
        e = sb_q.pop_front();
        for (int k = 0; k < 16; k++) chk($sformatf("c%0d d16[%0d]", cyc, k), 32'(d16[k]), 32'(e.a.lane[k]));
        chk($sformatf("c%0d v16", cyc), 32'(v16), 32'(e.a.valid));
        chk($sformatf("c%0d busy16", cyc), 32'(busy16), 32'(e.a.st != 2'd0));
        chk($sformatf("c%0d done16", cyc), 32'(done16), 32'(e.a.st == 2'd2));
        for (int k = 0; k < 12; k++) chk($sformatf("c%0d d12[%0d]", cyc, k), 32'(d12[k]), 32'(e.b.lane[k]));
        chk($sformatf("c%0d v12", cyc), 32'(v12), 32'(e.b.valid[11:0]));
        chk($sformatf("c%0d busy12", cyc), 32'(busy12), 32'(e.b.st != 2'd0));
        chk($sformatf("c%0d done12", cyc), 32'(done12), 32'(e.b.st == 2'd2));
        if (done16) begin
            done_cnt++;
            done_edge = cyc;
        end
        @(negedge clk);
    endtask

    task automatic drive(input logic w, input logic f, input logic c, input logic [3:0] s, input logic [3:0] d);
        wr = w; fill = f; clr = c; sel = s; data = d;
    endtask

    initial begin
        clk = 0; rst = 1; m16 = '0; m12 = '0;
        drive(0, 0, 0, 0, 0);
        #12;
        chk("rst busy", 32'(busy16), 0);
        chk("rst done", 32'(done16), 0);
        chk("rst valid", 32'(v16), 0);
        for (int k = 0; k < 16; k++) chk($sformatf("rst d16[%0d]", k), 32'(d16[k]), 0);
        @(negedge clk);
        rst = 0;

        // Addressed write to lane 5
        drive(1, 0, 0, 4'd5, 4'hA); cycle();
        chk("wr5 lane5", 32'(d16[5]), 32'hA);
        chk("wr5 valid", 32'(v16), 32'h0020);
        chk("wr5 lane4", 32'(d16[4]), 0);
        drive(0, 0, 1, 0, 0); cycle();

        // Full fill with wr held high, data = lane index
        done_cnt = 0;
        drive(0, 1, 0, 0, 0); cycle();
        fill_edge = cyc;
        for (int k = 0; k < 16; k++) begin
            drive(1, 0, 0, 4'd1, 4'(k)); cycle();
        end
        drive(0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) cycle();
        for (int k = 0; k < 16; k++) chk($sformatf("fill d16[%0d]", k), 32'(d16[k]), 32'(k));
        chk("fill valid", 32'(v16), 32'hFFFF);
        chk("fill done count", 32'(done_cnt), 1);
        chk("fill span", 32'(done_edge - fill_edge + 2), 32'(16 + 2));

        // Stall after lane 6 for three cycles
        drive(0, 0, 1, 0, 0); cycle();
        drive(0, 1, 0, 0, 0); cycle();
        for (int k = 0; k < 7; k++) begin
            drive(1, 0, 0, 4'd0, 4'(k + 1)); cycle();
        end
        drive(0, 1, 0, 4'd2, 4'hE);
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("stall busy", 32'(busy16), 1);
            chk("stall lane7", 32'(d16[7]), 0);
        end
        drive(1, 0, 0, 4'd2, 4'hC); cycle();
        chk("resume lane7", 32'(d16[7]), 32'hC);
        chk("resume lane6", 32'(d16[6]), 32'h7);
        chk("resume lane8", 32'(d16[8]), 0);
        chk("resume lane2", 32'(d16[2]), 32'h3);

        // Clear mid-fill, then clear beats a write in IDLE
        drive(0, 0, 1, 0, 0); cycle();
        drive(1, 0, 0, 4'd3, 4'h9); cycle();
        drive(1, 0, 0, 4'd1, 4'h2); cycle();
        drive(1, 0, 1, 4'd3, 4'hF); cycle();
        chk("clr valid", 32'(v16), 0);
        chk("clr lane3", 32'(d16[3]), 0);
        chk("clr busy", 32'(busy16), 0);

        // Async reset during fill at lane 9
        drive(0, 1, 0, 0, 0); cycle();
        for (int k = 0; k < 9; k++) begin
            drive(1, 0, 0, 4'd0, 4'(15 - k)); cycle();
        end
        drive(1, 0, 0, 4'd0, 4'h5);
        #2 rst = 1;
        #1;
        chk("arst busy", 32'(busy16), 0);
        chk("arst valid", 32'(v16), 0);
        chk("arst lane0", 32'(d16[0]), 0);
        chk("arst done", 32'(done16), 0);
        m16 = '0; m12 = '0;
        @(negedge clk);
        rst = 0;
        done_cnt = 0;
        drive(1, 0, 0, 4'd2, 4'h6); cycle();
        chk("post-rst first edge", 32'(d16[2]), 32'h6);
        drive(0, 0, 0, 0, 0);
        for (int k = 0; k < 20; k++) cycle();
        chk("post-rst no done", 32'(done_cnt), 0);

        // Out-of-range select on the 12-lane instance
        drive(1, 0, 0, 4'd4, 4'h3); cycle();
        saved = m12;
        drive(1, 0, 0, 4'd13, 4'h7); cycle();
        chk("m12 sel13 valid", 32'(v12), 32'(saved.valid[11:0]));
        for (int k = 0; k < 12; k++) chk($sformatf("m12 sel13 d12[%0d]", k), 32'(d12[k]), 32'(saved.lane[k]));
        chk("m12 sel13 busy", 32'(busy12), 0);
        chk("m16 sel13 lane13", 32'(d16[13]), 32'h7);

        drive(0, 0, 0, 0, 0); cycle();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
